// File: rtl/sat_search_driver_if.sv
// Link between the search driver and the combinational circuit under test:
// candidate assignment out, single sat result back.
interface sat_search_driver_if #(
  parameter int NUM_INPUTS = 11
);
  logic [NUM_INPUTS-1:0] assignment_out;
  logic                  assign_valid;
  logic                  sat_in;

  modport master (
    output assignment_out,
    output assign_valid,
    input  sat_in
  );

  modport slave (
    input  assignment_out,
    input  assign_valid,
    output sat_in
  );
endinterface

// File: rtl/sat_search_driver.sv
// Exhaustive SAT search driver: issues one candidate per clock, matches delayed sat results
// to their candidates, stops on the first hit. Optional hit counter: SAT_SEARCH_SOLUTION_COUNT_EN.
module sat_search_driver #(
  parameter int NUM_INPUTS  = 11,
  parameter int PIPE_STAGES = 0,
  parameter int CYC_W       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  resume,
  sat_search_driver_if.master   cir,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted,
  output logic [NUM_INPUTS-1:0] solution,
  output logic [CYC_W-1:0]      search_cycles
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
  ,
  output logic [NUM_INPUTS:0]   solution_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_DRAIN,
    S_FOUND,
    S_EXHAUSTED
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_INPUTS-1:0] assign_q, assign_d;
  logic [NUM_INPUTS-1:0] solution_q, solution_d;
  logic [CYC_W-1:0]      cycles_q, cycles_d;

  logic                  issuing;
  logic                  match_valid;
  logic [NUM_INPUTS-1:0] match_assign;
  logic                  hit;

  assign issuing = (state_q == S_SEARCH);
  assign busy    = (state_q == S_SEARCH) || (state_q == S_DRAIN);
  // A result only counts while searching and only against a live tag.
  assign hit     = busy && cir.sat_in && match_valid;

  if (PIPE_STAGES > 0) begin : g_pipe
    logic [PIPE_STAGES-1:0]                 tag_valid_q, tag_valid_d;
    logic [PIPE_STAGES-1:0][NUM_INPUTS-1:0] tag_assign_q, tag_assign_d;

    always_comb begin
      tag_valid_d     = '0;
      tag_assign_d    = tag_assign_q;
      tag_valid_d[0]  = issuing && !hit;
      tag_assign_d[0] = assign_q;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        tag_valid_d[i]  = tag_valid_q[i-1] && !hit;
        tag_assign_d[i] = tag_assign_q[i-1];
      end
    end

    // NOTE: only the valid bits matter functionally, but the whole tag store is
    // cleared so a reset leaves no stale candidate visible in the pipe.
    always_ff @(posedge clock) begin
      if (reset) begin
        tag_valid_q  <= '0;
        tag_assign_q <= '0;
      end else begin
        tag_valid_q  <= tag_valid_d;
        tag_assign_q <= tag_assign_d;
      end
    end

    assign match_valid  = tag_valid_q[PIPE_STAGES-1];
    assign match_assign = tag_assign_q[PIPE_STAGES-1];
  end else begin : g_comb
    assign match_valid  = issuing;
    assign match_assign = assign_q;
  end

`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
  logic [NUM_INPUTS:0] count_q, count_d;
  assign solution_count = count_q;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    assign_d   = assign_q;
    solution_d = solution_q;
    cycles_d   = cycles_q;
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
    count_d    = count_q;
`endif

    if (busy && (cycles_q != '1)) begin
      cycles_d = cycles_q + CYC_W'(1);
    end

    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (start) begin
          state_d  = S_SEARCH;
          assign_d = '0;
          cycles_d = '0;
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
          count_d  = '0;
`endif
        end else if (resume && (state_q == S_FOUND)) begin
          if (solution_q == '1) begin
            state_d = S_EXHAUSTED;
          end else begin
            state_d  = S_SEARCH;
            assign_d = solution_q + NUM_INPUTS'(1);
          end
        end
      end
      S_SEARCH: begin
        if (hit) begin
          state_d = S_FOUND;
        end else if (assign_q == '1) begin
          // Last candidate issued: wait for its result if it is still in flight.
          state_d = (PIPE_STAGES == 0) ? S_EXHAUSTED : S_DRAIN;
        end else begin
          assign_d = assign_q + NUM_INPUTS'(1);
        end
      end
      S_DRAIN: begin
        if (hit) begin
          state_d = S_FOUND;
        end else if (match_valid && (match_assign == '1)) begin
          state_d = S_EXHAUSTED;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (hit) begin
      solution_d = match_assign;
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
      if (count_q != '1) begin
        count_d = count_q + (NUM_INPUTS + 1)'(1);
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      assign_q   <= '0;
      solution_q <= '0;
      cycles_q   <= '0;
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
      count_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      assign_q   <= assign_d;
      solution_q <= solution_d;
      cycles_q   <= cycles_d;
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
      count_q    <= count_d;
`endif
    end
  end

  assign cir.assignment_out = assign_q;
  assign cir.assign_valid   = issuing;
  assign found              = (state_q == S_FOUND);
  assign exhausted          = (state_q == S_EXHAUSTED);
  assign solution           = solution_q;
  assign search_cycles      = cycles_q;

endmodule

// File: tb/tb_sat_search_driver.sv
// Scoreboard bench for sat_search_driver: four instances (4/0, 4/2, 4/3, 11/0 inputs/stages)
// driven by directed vectors; monitors pop expected completions and candidate traces.
module tb_sat_search_driver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [3:0] rst, st, rs;
  logic [3:0] busy_w, found_w, exh_w;
  logic [3:0] sol_a, sol_b, sol_c;
  logic [10:0] sol_d;
  logic [31:0] cyc_w [4];

  sat_search_driver_if #(.NUM_INPUTS(4))  if_a (), if_b (), if_c ();
  sat_search_driver_if #(.NUM_INPUTS(11)) if_d ();

`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
  logic [4:0]  cnt_a, cnt_b, cnt_c;
  logic [11:0] cnt_d;
  logic [11:0] m_cnt [4];
  assign m_cnt[0] = {7'd0, cnt_a};
  assign m_cnt[1] = {7'd0, cnt_b};
  assign m_cnt[2] = {7'd0, cnt_c};
  assign m_cnt[3] = cnt_d;
`endif

  sat_search_driver #(.NUM_INPUTS(4), .PIPE_STAGES(0), .CYC_W(32)) u_a (
    .clock(clock), .reset(rst[0]), .start(st[0]), .resume(rs[0]), .cir(if_a),
    .busy(busy_w[0]), .found(found_w[0]), .exhausted(exh_w[0]),
    .solution(sol_a), .search_cycles(cyc_w[0])
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
    , .solution_count(cnt_a)
`endif
  );

  sat_search_driver #(.NUM_INPUTS(4), .PIPE_STAGES(2), .CYC_W(32)) u_b (
    .clock(clock), .reset(rst[1]), .start(st[1]), .resume(rs[1]), .cir(if_b),
    .busy(busy_w[1]), .found(found_w[1]), .exhausted(exh_w[1]),
    .solution(sol_b), .search_cycles(cyc_w[1])
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
    , .solution_count(cnt_b)
`endif
  );

  sat_search_driver #(.NUM_INPUTS(4), .PIPE_STAGES(3), .CYC_W(32)) u_c (
    .clock(clock), .reset(rst[2]), .start(st[2]), .resume(rs[2]), .cir(if_c),
    .busy(busy_w[2]), .found(found_w[2]), .exhausted(exh_w[2]),
    .solution(sol_c), .search_cycles(cyc_w[2])
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
    , .solution_count(cnt_c)
`endif
  );

  sat_search_driver #(.NUM_INPUTS(11), .PIPE_STAGES(0), .CYC_W(32)) u_d (
    .clock(clock), .reset(rst[3]), .start(st[3]), .resume(rs[3]), .cir(if_d),
    .busy(busy_w[3]), .found(found_w[3]), .exhausted(exh_w[3]),
    .solution(sol_d), .search_cycles(cyc_w[3])
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
    , .solution_count(cnt_d)
`endif
  );

  // Circuit models: a/c combinational or constant, b delayed by two register stages.
  logic [15:0] mask_a, mask_b;
  logic [3:0]  b_d1 = '0, b_d2 = '0;
  always @(posedge clock) begin
    b_d1 <= if_b.assignment_out;
    b_d2 <= b_d1;
  end
  assign if_a.sat_in = mask_a[if_a.assignment_out];
  assign if_b.sat_in = mask_b[b_d2];
  assign if_c.sat_in = 1'b0;

  function automatic logic fact_sat(input logic [10:0] v);
    logic [10:0] prod;
    prod = 11'(v[6:0]) * 11'(v[10:7]);
    return (prod == 11'd221) && (v[6:0] != 7'd1) && (v[10:7] != 4'd1);
  endfunction
  assign if_d.sat_in = fact_sat(if_d.assignment_out);

  logic [3:0]  m_valid;
  logic [10:0] m_sol [4];
  assign m_valid  = {if_d.assign_valid, if_c.assign_valid, if_b.assign_valid, if_a.assign_valid};
  assign m_sol[0] = {7'd0, sol_a};
  assign m_sol[1] = {7'd0, sol_b};
  assign m_sol[2] = {7'd0, sol_c};
  assign m_sol[3] = sol_d;

  typedef struct {
    int          id;
    logic        found;
    logic        exh;
    logic [10:0] sol;
    logic [31:0] cycles;
    logic [11:0] cnt;
    int unsigned at;
  } exp_t;

  typedef struct {
    int          id;
    logic [10:0] val;
  } cand_t;

  exp_t  exp_q [$];
  cand_t cand_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no matching expectation (cycle %0d)", name, cyc);
  endtask

  task automatic trace(input int id, input logic [10:0] v);
    cand_t c;
    if (cand_q.size() == 0) begin
      fail_now($sformatf("dut%0d_extra_candidate_%0h", id, v));
    end else begin
      c = cand_q.pop_front();
      check($sformatf("dut%0d_cand_owner", id), id, c.id);
      check($sformatf("dut%0d_candidate", id), {21'd0, v}, {21'd0, c.val});
    end
  endtask

  // Completion monitor: a rising found or exhausted pops and checks one expectation.
  logic [3:0] prev_found = '0, prev_exh = '0;
  exp_t mon_e;
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if ((found_w[i] && !prev_found[i]) || (exh_w[i] && !prev_exh[i])) begin
        if (exp_q.size() == 0) begin
          fail_now($sformatf("dut%0d_unexpected_done", i));
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("dut%0d_done_owner", i), i, mon_e.id);
          check($sformatf("dut%0d_done_cycle", i), cyc, mon_e.at);
          check($sformatf("dut%0d_found", i), found_w[i], mon_e.found);
          check($sformatf("dut%0d_exhausted", i), exh_w[i], mon_e.exh);
          check($sformatf("dut%0d_solution", i), {21'd0, m_sol[i]}, {21'd0, mon_e.sol});
          check($sformatf("dut%0d_search_cycles", i), cyc_w[i], mon_e.cycles);
          check($sformatf("dut%0d_busy_at_done", i), busy_w[i], 0);
          check($sformatf("dut%0d_valid_at_done", i), m_valid[i], 0);
`ifdef SAT_SEARCH_SOLUTION_COUNT_EN
          check($sformatf("dut%0d_solution_count", i), {20'd0, m_cnt[i]}, {20'd0, mon_e.cnt});
`endif
        end
      end
    end
    if (if_a.assign_valid) trace(0, {7'd0, if_a.assignment_out});
    if (if_b.assign_valid) trace(1, {7'd0, if_b.assignment_out});
    prev_found <= found_w;
    prev_exh   <= exh_w;
  end

  task automatic push_cands(input int id, input int lo, input int hi);
    cand_t c;
    for (int v = lo; v <= hi; v++) begin
      c.id  = id;
      c.val = 11'(v);
      cand_q.push_back(c);
    end
  endtask

  task automatic go(input int id, input logic s, input logic r, input bit push,
                    input int unsigned lat, input logic f, input logic x,
                    input logic [10:0] sol, input logic [31:0] cycles, input logic [11:0] cnt);
    exp_t e;
    @(negedge clock);
    if (push) begin
      e.id = id; e.found = f; e.exh = x; e.sol = sol;
      e.cycles = cycles; e.cnt = cnt; e.at = cyc + lat;
      exp_q.push_back(e);
    end
    st[id] = s;
    rs[id] = r;
    @(negedge clock);
    st[id] = 1'b0;
    rs[id] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (exp_q.size() != 0) begin
      fail_now("completion_timeout");
      exp_q.delete();
    end
  endtask

  initial begin
    rst    = '1;
    st     = '0;
    rs     = '0;
    mask_a = 16'h0020;
    mask_b = 16'h8020;
    repeat (3) @(negedge clock);

    check("rst_busy", {28'd0, busy_w}, 0);
    check("rst_found", {28'd0, found_w}, 0);
    check("rst_exhausted", {28'd0, exh_w}, 0);
    check("rst_valid", {28'd0, m_valid}, 0);
    check("rst_a_assignment", {28'd0, if_a.assignment_out}, 0);
    check("rst_d_assignment", {21'd0, if_d.assignment_out}, 0);
    check("rst_d_solution", {21'd0, sol_d}, 0);
    check("rst_b_cycles", cyc_w[1], 0);
    rst = '0;

    // Single hit at 5, combinational path.
    push_cands(0, 0, 5);
    go(0, 1, 0, 1, 7, 1, 0, 11'd5, 6, 1);
    wait_done(50);

    // Same hit through two stages; 6 and 7 are issued then discarded.
    push_cands(1, 0, 7);
    go(1, 1, 0, 1, 9, 1, 0, 11'd5, 8, 1);
    wait_done(50);
    push_cands(1, 6, 15);
    go(1, 0, 1, 1, 13, 1, 0, 11'd15, 20, 2);
    wait_done(50);
    go(1, 0, 1, 1, 1, 0, 1, 11'd15, 20, 2);
    wait_done(10);
    repeat (3) @(negedge clock);
    check("b_exhausted_held", exh_w[1], 1);
    check("b_idle_after_exhaust", busy_w[1], 0);

    // Factorisation of 221 with 11 inputs.
    go(3, 1, 0, 1, 1683, 1, 0, 11'h691, 1682, 1);
    wait_done(2000);

    // No solution with three stages: 16 search cycles then 3 drain cycles.
    go(2, 1, 0, 1, 20, 0, 1, 11'd0, 19, 0);
    repeat (16) @(negedge clock);
    check("c_drain_busy", busy_w[2], 1);
    check("c_drain_valid", if_c.assign_valid, 0);
    check("c_drain_assignment", {28'd0, if_c.assignment_out}, 32'hF);
    wait_done(20);

    // start together with resume in FOUND restarts from 0.
    push_cands(0, 0, 5);
    go(0, 1, 1, 1, 7, 1, 0, 11'd5, 6, 1);
    wait_done(50);

    // A second start while busy must not restart the sweep.
    push_cands(0, 0, 5);
    go(0, 1, 0, 1, 7, 1, 0, 11'd5, 6, 1);
    check("a_busy_after_start", busy_w[0], 1);
    go(0, 1, 0, 0, 0, 0, 0, 11'd0, 0, 0);
    wait_done(50);

    // Reset on the fourth search cycle (assignment 3 on the bus).
    push_cands(0, 0, 3);
    go(0, 1, 0, 0, 0, 0, 0, 11'd0, 0, 0);
    repeat (3) @(negedge clock);
    check("a_pre_reset_assignment", {28'd0, if_a.assignment_out}, 3);
    rst[0] = 1'b1;
    @(negedge clock);
    check("a_reset_busy", busy_w[0], 0);
    check("a_reset_found", found_w[0], 0);
    check("a_reset_exhausted", exh_w[0], 0);
    check("a_reset_valid", if_a.assign_valid, 0);
    check("a_reset_assignment", {28'd0, if_a.assignment_out}, 0);
    check("a_reset_solution", {28'd0, sol_a}, 0);
    check("a_reset_cycles", cyc_w[0], 0);
    rst[0] = 1'b0;
    repeat (3) @(negedge clock);
    check("a_stays_idle", busy_w[0], 0);

    check("leftover_candidates", cand_q.size(), 0);
    check("leftover_completions", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
